instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 30 +++
 rtl/instr_fetch_unit_mem.sv | 32 +++
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, FSM encoding and sizing.
package instr_fetch_unit_pkg;

    localparam int PC_W      = 8;
    localparam int MEM_DEPTH = 256;
    localparam int INSTR_W   = 32;

    localparam logic [PC_W-1:0] PC_ZERO = 8'd0;
    localparam logic [PC_W-1:0] PC_ONE  = 8'd1;

    localparam logic [3:0] OP_LOAD   = 4'h0;
    localparam logic [3:0] OP_MOV    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_ADD    = 4'h3;
    localparam logic [3:0] OP_LDPC   = 4'h4;
    localparam logic [3:0] OP_BRANCH = 4'h5;
    localparam logic [3:0] OP_HALT   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // The fetch unit only ever needs to recognise the halt opcode.
    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return (word[31:28] == OP_HALT);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_mem.sv
// Instruction store: one synchronous write port, one combinational read port, never reset.
module instr_mem
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = instr_fetch_unit_pkg::MEM_DEPTH
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PC_W-1:0]    waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [PC_W-1:0]    raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem_r [DEPTH];
    logic [INSTR_W-1:0] rdata_s;

    // Program-load write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Asynchronous read feeding the fetch output register
    always_comb begin
        rdata_s = mem_r[raddr];
    end

    assign rdata = rdata_s;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program load, sequential fetch with backpressure, branch flush, halt.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int MEM_DEPTH = instr_fetch_unit_pkg::MEM_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_valid,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic               prog_ready,
    input  logic               start,
    input  logic               branch_valid,
    input  logic [PC_W-1:0]    branch_target,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               halted
);

    state_e             state_r;
    logic [PC_W-1:0]    pc_r;
    logic [INSTR_W-1:0] instr_r;
    logic [PC_W-1:0]    instr_pc_r;
    logic               instr_valid_r;
    logic               halted_r;
    logic               prog_ready_r;
    logic               write_en_s;
    logic [INSTR_W-1:0] rdata_s;

    // prog_ready is a register mirroring IDLE/HALT, so writes are gated without decoding state
    assign write_en_s = prog_valid && prog_ready_r;

    instr_mem #(
        .DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (write_en_s),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_r),
        .rdata (rdata_s)
    );

    // Fetch control FSM with its registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pc_r          <= PC_ZERO;
            instr_r       <= 32'h0000_0000;
            instr_pc_r    <= PC_ZERO;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
            prog_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_r       <= ST_FETCH;
                        pc_r          <= PC_ZERO;
                        instr_valid_r <= 1'b0;
                        halted_r      <= 1'b0;
                        prog_ready_r  <= 1'b0;
                    end else if (instr_valid_r && instr_ready) begin
                        // the halt word is retired once downstream takes it
                        instr_valid_r <= 1'b0;
                    end else begin
                        instr_valid_r <= instr_valid_r;
                    end
                end
                ST_FETCH: begin
                    if (branch_valid) begin
                        pc_r          <= branch_target;
                        instr_valid_r <= 1'b0;
                    end else if (!instr_valid_r || instr_ready) begin
                        instr_r       <= rdata_s;
                        instr_pc_r    <= pc_r;
                        instr_valid_r <= 1'b1;
                        pc_r          <= pc_r + PC_ONE;
                        if (is_halt(rdata_s)) begin
                            state_r      <= ST_HALT;
                            halted_r     <= 1'b1;
                            prog_ready_r <= 1'b1;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    pc_r          <= PC_ZERO;
                    instr_valid_r <= 1'b0;
                    halted_r      <= 1'b0;
                    prog_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_r;
    assign halted      = halted_r;
    assign prog_ready  = prog_ready_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_valid = 1'b0;
    logic [7:0]  prog_addr = 8'd0;
    logic [31:0] prog_data = 32'd0;
    logic        prog_ready;
    logic        start = 1'b0;
    logic        branch_valid = 1'b0;
    logic [7:0]  branch_target = 8'd0;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        halted;

    int checks = 0;
    int passed = 0;

    instr_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .prog_valid    (prog_valid),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .prog_ready    (prog_ready),
        .start         (start),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [7:0] a, input logic [31:0] d);
        prog_valid = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if ({instr_valid, halted, prog_ready} !== 3'b001) $display("FAIL reset_flags: got %b expected 001", {instr_valid, halted, prog_ready}); else passed++;
        checks++; if ({instr, instr_pc} !== 40'd0) $display("FAIL reset_instr: got %h/%h expected 0/0", instr, instr_pc); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_run();
        prog_write(8'd0, 32'h0000_0005);
        prog_write(8'd1, 32'h3010_0000);
        prog_write(8'd2, 32'hF000_0000);
        instr_ready = 1'b1;
        pulse_start();
        checks++; if ({instr_valid, prog_ready} !== 2'b00) $display("FAIL start_state: got valid/ready %b expected 00", {instr_valid, prog_ready}); else passed++;
        tick();
        checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h0000_0005, 8'd0}) $display("FAIL basic_w0: got %b %h %h expected 1 00000005 00", instr_valid, instr, instr_pc); else passed++;
        tick();
        checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h3010_0000, 8'd1}) $display("FAIL basic_w1: got %b %h %h expected 1 30100000 01", instr_valid, instr, instr_pc); else passed++;
        tick();
        checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hF000_0000, 8'd2}) $display("FAIL basic_w2: got %b %h %h expected 1 f0000000 02", instr_valid, instr, instr_pc); else passed++;
        tick();
        checks++; if ({instr_valid, halted, prog_ready} !== 3'b011) $display("FAIL basic_halt: got valid/halted/ready %b expected 011", {instr_valid, halted, prog_ready}); else passed++;
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b1;
        pulse_start();
        tick(); tick();
        checks++; if (instr_pc !== 8'd1) $display("FAIL bp_reach: got pc %h expected 01", instr_pc); else passed++;
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h3010_0000, 8'd1}) $display("FAIL bp_hold%0d: got %b %h %h expected 1 30100000 01", i, instr_valid, instr, instr_pc); else passed++;
        end
        checks++; if (dut.pc_r !== 8'd2) $display("FAIL bp_pc: got %h expected 02", dut.pc_r); else passed++;
        instr_ready = 1'b1;
        tick();
        checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hF000_0000, 8'd2}) $display("FAIL bp_next: got %b %h %h expected 1 f0000000 02", instr_valid, instr, instr_pc); else passed++;
        tick();
        checks++; if ({instr_valid, halted} !== 2'b01) $display("FAIL bp_halt: got %b expected 01", {instr_valid, halted}); else passed++;
    endtask

    task automatic test_branch();
        for (int i = 0; i < 8; i++) prog_write(8'(i), 32'h1000_0000 | 32'(i));
        prog_write(8'h40, 32'h2040_00AA);
        prog_write(8'h41, 32'hF000_0041);
        instr_ready = 1'b1;
        pulse_start();
        repeat (6) tick();
        checks++; if ({instr, instr_pc} !== {32'h1000_0005, 8'd5}) $display("FAIL br_at5: got %h %h expected 10000005 05", instr, instr_pc); else passed++;
        instr_ready = 1'b0; branch_valid = 1'b1; branch_target = 8'h40;
        tick();
        branch_valid = 1'b0;
        checks++; if ({instr_valid, dut.pc_r} !== {1'b0, 8'h40}) $display("FAIL br_flush: got %b %h expected 0 40", instr_valid, dut.pc_r); else passed++;
        tick();
        checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h2040_00AA, 8'h40}) $display("FAIL br_target: got %b %h %h expected 1 204000aa 40", instr_valid, instr, instr_pc); else passed++;
        instr_ready = 1'b1;
        tick();
        checks++; if ({halted, instr_pc} !== {1'b1, 8'h41}) $display("FAIL br_halt: got %b %h expected 1 41", halted, instr_pc); else passed++;
        tick();
        branch_valid = 1'b1; branch_target = 8'h10;
        tick();
        branch_valid = 1'b0;
        checks++; if ({halted, instr_valid, dut.pc_r} !== {1'b1, 1'b0, 8'h42}) $display("FAIL br_in_halt: got %b %b %h expected 1 0 42", halted, instr_valid, dut.pc_r); else passed++;
    endtask

    task automatic test_prog_in_fetch();
        prog_write(8'd0, 32'h0000_0010);
        prog_write(8'd1, 32'h5000_0011);
        prog_write(8'd2, 32'h2000_0012);
        prog_write(8'd3, 32'h3333_0003);
        prog_write(8'd4, 32'hF000_0004);
        instr_ready = 1'b1;
        pulse_start();
        checks++; if (prog_ready !== 1'b0) $display("FAIL pf_ready: got %b expected 0", prog_ready); else passed++;
        prog_valid = 1'b1; prog_addr = 8'd3; prog_data = 32'hDEAD_BEEF;
        tick();
        prog_valid = 1'b0;
        tick();
        checks++; if (instr !== 32'h5000_0011) $display("FAIL pf_passthru: got %h expected 50000011", instr); else passed++;
        tick(); tick(); tick(); tick();
        checks++; if (halted !== 1'b1) $display("FAIL pf_halt1: got %b expected 1", halted); else passed++;
        // write and start in the same cycle
        prog_valid = 1'b1; prog_addr = 8'd0; prog_data = 32'h4000_0077; start = 1'b1;
        tick();
        prog_valid = 1'b0; start = 1'b0;
        tick();
        checks++; if ({instr, instr_pc} !== {32'h4000_0077, 8'd0}) $display("FAIL pf_wr_start: got %h %h expected 40000077 00", instr, instr_pc); else passed++;
        tick(); tick(); tick();
        checks++; if ({instr, instr_pc} !== {32'h3333_0003, 8'd3}) $display("FAIL pf_orig3: got %h %h expected 33330003 03", instr, instr_pc); else passed++;
        tick(); tick();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) prog_write(8'(i), 32'h6000_0000 | 32'(i));
        instr_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 128) begin
                checks++; if ({instr, instr_pc} !== {32'h6000_0080, 8'h80}) $display("FAIL wrap_mid: got %h %h expected 60000080 80", instr, instr_pc); else passed++;
            end
        end
        checks++; if ({instr, instr_pc} !== {32'h6000_00FF, 8'hFF}) $display("FAIL wrap_255: got %h %h expected 600000ff ff", instr, instr_pc); else passed++;
        tick();
        checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h6000_0000, 8'h00}) $display("FAIL wrap_0: got %b %h %h expected 1 60000000 00", instr_valid, instr, instr_pc); else passed++;
    endtask

    task automatic test_reset_mid();
        tick(); tick();
        #1 rst = 1'b1;
        #1;
        checks++; if ({instr_valid, dut.pc_r} !== {1'b0, 8'd0}) $display("FAIL rst_async: got %b %h expected 0 00", instr_valid, dut.pc_r); else passed++;
        checks++; if ({halted, prog_ready, instr_pc} !== {2'b01, 8'd0}) $display("FAIL rst_outputs: got %b %b %h expected 0 1 00", halted, prog_ready, instr_pc); else passed++;
        #1 rst = 1'b0;
        tick();
        pulse_start();
        tick();
        checks++; if ({instr, instr_pc} !== {32'h6000_0000, 8'd0}) $display("FAIL rerun_0: got %h %h expected 60000000 00", instr, instr_pc); else passed++;
        tick();
        checks++; if ({instr, instr_pc} !== {32'h6000_0001, 8'd1}) $display("FAIL rerun_1: got %h %h expected 60000001 01", instr, instr_pc); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_backpressure();
        test_branch();
        test_prog_in_fetch();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
